// File: rtl/free_list_if.sv
// free_list_if: dispatch/retire/recover bus between the ROB side and the free list
interface free_list_if #(
  parameter int TAG_W = 7
);
  logic [1:0]       rs_mt_fl_dispatch_num;
  logic [1:0]       fl_retire_num;
  logic [TAG_W-1:0] fl_retire_tag_a;
  logic [TAG_W-1:0] fl_retire_tag_b;
  logic             recover;
  logic [TAG_W-1:0] fl_pr0;
  logic [TAG_W-1:0] fl_pr1;
  logic [1:0]       fl_avail;
  logic [5:0]       fl_free_count;
  modport master (
    output rs_mt_fl_dispatch_num, fl_retire_num, fl_retire_tag_a, fl_retire_tag_b, recover,
    input  fl_pr0, fl_pr1, fl_avail, fl_free_count
  );
  modport slave (
    input  rs_mt_fl_dispatch_num, fl_retire_num, fl_retire_tag_a, fl_retire_tag_b, recover,
    output fl_pr0, fl_pr1, fl_avail, fl_free_count
  );
endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical tags, two-wide alloc/retire, one-cycle recovery
module free_list #(
  parameter int NUM_PR = 64,
  parameter int NUM_AR = 32,
  parameter int TAG_W  = 7
) (
  input logic        clock,
  input logic        reset,
  free_list_if.slave fl
);
  localparam int FL_SIZE = NUM_PR - NUM_AR;
  localparam int PTR_W   = $clog2(FL_SIZE);
  localparam int CNT_W   = $clog2(FL_SIZE + 1);
  logic [TAG_W-1:0] mem [FL_SIZE];
  logic [PTR_W-1:0] head, ret_head, tail;
  logic [PTR_W-1:0] head_next, ret_head_next, tail_p1;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       disp, n, avail, alloc;
  always_comb begin
    disp          = fl.rs_mt_fl_dispatch_num == 2'd3 ? 2'd2 : fl.rs_mt_fl_dispatch_num;
    n             = fl.fl_retire_num == 2'd3 ? 2'd2 : fl.fl_retire_num;
    avail         = cnt >= CNT_W'(2) ? 2'd2 : cnt[1:0];
    alloc         = disp < avail ? disp : avail;
    tail_p1       = tail + PTR_W'(1);
    ret_head_next = ret_head + PTR_W'(n);
    // recovery rewinds head to the retire point, including tags retiring this same edge
    head_next     = fl.recover ? ret_head_next : head + PTR_W'(alloc);
    cnt_next      = fl.recover ? CNT_W'(FL_SIZE) : cnt - CNT_W'(alloc) + CNT_W'(n);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) mem[i] <= TAG_W'(NUM_AR + i);
      head     <= '0;
      ret_head <= '0;
      tail     <= '0;
      cnt      <= CNT_W'(FL_SIZE);
    end else begin
      if (n != 2'd0) mem[tail] <= fl.fl_retire_tag_a;
      if (n == 2'd2) mem[tail_p1] <= fl.fl_retire_tag_b;
      head     <= head_next;
      ret_head <= ret_head_next;
      tail     <= tail + PTR_W'(n);
      cnt      <= cnt_next;
    end
  end
  assign fl.fl_pr0        = mem[head];
  assign fl.fl_pr1        = mem[head + PTR_W'(1)];
  assign fl.fl_avail      = avail;
  assign fl.fl_free_count = 6'(cnt);
endmodule
